// File: rtl/uart_mmio_pkg.sv
// Shared constants for the memory-mapped UART: bus addresses, CON bit positions
// and the state encoding used by both the TX and RX state machines.
package uart_mmio_pkg;

    localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
    localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
    localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

    localparam int CON_TX_IRQ_EN  = 0;
    localparam int CON_RX_IRQ_EN  = 1;
    localparam int CON_TX_DONE    = 2;
    localparam int CON_RX_READY   = 3;
    localparam int CON_TX_BUSY    = 4;
    localparam int CON_RX_OVERRUN = 5;
    localparam int CON_WIDTH      = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchroniser, 8N1 deserialiser with mid-bit sampling.
// Emits the received byte with a one-cycle byte_valid_o pulse; framing errors are dropped.
module uart_rx_core
    import uart_mmio_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n_i,
    input  logic       rxd_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic          sync1_q, sync2_q;
    uart_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
        end else begin
            sync1_q <= rxd_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // The detection cycle already counts toward the half-bit delay.
                if (!sync2_q) begin
                    state_d = START;
                    cnt_d   = CW'(1);
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    valid_d = sync2_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = valid_q;

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART at 0x4000_0018..0x4000_0020: bus decode, TX FSM and CON/TXD/RXD registers.
// Optional overrun flag in CON[5] is built only when UART_RX_OVERRUN_EN is defined.
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    input  logic        uart_rxd,
    output logic        uart_txd,
    output logic        irq
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic sel_txd, sel_rxd, sel_con;
    logic tx_start, con_wr, con_rd, rxd_rd, tx_end, tx_busy;

    uart_state_t   tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    txd_q, txd_d;
    logic [7:0]    rxd_q, rxd_d;
    logic [1:0]    irq_en_q, irq_en_d;
    logic          tx_done_q, tx_done_d;
    logic          rx_ready_q, rx_ready_d;
    logic          rx_overrun;

    logic [7:0]    rx_byte;
    logic          rx_byte_valid;
    logic [CON_WIDTH-1:0] con_val;
    logic          unused_wdata;

    assign sel_txd  = (Address == UART_TXD_ADDR);
    assign sel_rxd  = (Address == UART_RXD_ADDR);
    assign sel_con  = (Address == UART_CON_ADDR);
    assign tx_busy  = (tx_state_q != IDLE);
    assign tx_start = MemWrite && sel_txd && !tx_busy;
    assign con_wr   = MemWrite && sel_con;
    assign con_rd   = MemRead && sel_con;
    assign rxd_rd   = MemRead && sel_rxd;
    assign tx_end   = (tx_state_q == STOP) && (tx_cnt_q == CNT_LAST);
    assign unused_wdata = ^Write_data[31:8];

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk          (clk),
        .rst_n_i      (reset),
        .rxd_i        (uart_rxd),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_byte_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            txd_q      <= '0;
            rxd_q      <= '0;
            irq_en_q   <= '0;
            tx_done_q  <= 1'b0;
            rx_ready_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            txd_q      <= txd_d;
            rxd_q      <= rxd_d;
            irq_en_q   <= irq_en_d;
            tx_done_q  <= tx_done_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        txd_d      = txd_q;
        uart_txd   = 1'b1;
        unique case (tx_state_q)
            IDLE: begin
                tx_cnt_d = '0;
                if (tx_start) begin
                    txd_d      = Write_data[7:0];
                    tx_bit_d   = '0;
                    tx_state_d = START;
                end
            end
            START: begin
                uart_txd = 1'b0;
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = DATA;
                end
            end
            DATA: begin
                uart_txd = txd_q[tx_bit_q];
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    tx_bit_d = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = STOP;
                end
            end
            STOP: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = IDLE;
                end
            end
            default: tx_state_d = IDLE;
        endcase
    end

    // Set beats a same-cycle clear for both status flags.
    always_comb begin
        irq_en_d   = con_wr ? Write_data[1:0] : irq_en_q;
        tx_done_d  = tx_end ? 1'b1 : (con_rd ? 1'b0 : tx_done_q);
        rx_ready_d = rx_byte_valid ? 1'b1 : (rxd_rd ? 1'b0 : rx_ready_q);
        rxd_d      = rx_byte_valid ? rx_byte : rxd_q;
    end

`ifdef UART_RX_OVERRUN_EN
    logic rx_overrun_q, rx_overrun_d;

    always_comb begin
        rx_overrun_d = (rx_byte_valid && rx_ready_q) ? 1'b1 : (con_rd ? 1'b0 : rx_overrun_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rx_overrun_q <= 1'b0;
        else        rx_overrun_q <= rx_overrun_d;
    end

    assign rx_overrun = rx_overrun_q;
`else
    assign rx_overrun = 1'b0;
`endif

    assign con_val = {3'b000, rx_overrun, tx_busy, rx_ready_q, tx_done_q, irq_en_q};
    assign irq = (irq_en_q[CON_TX_IRQ_EN] && tx_done_q) || (irq_en_q[CON_RX_IRQ_EN] && rx_ready_q);

    always_comb begin
        Read_data = '0;
        if (MemRead) begin
            if (sel_txd)      Read_data = {24'd0, txd_q};
            else if (sel_rxd) Read_data = {24'd0, rxd_q};
            else if (sel_con) Read_data = {{(32 - CON_WIDTH){1'b0}}, con_val};
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed and randomised bench for uart_mmio with a flag-level model of the register file.
module tb_uart_mmio;
    import uart_mmio_pkg::*;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] Write_data = '0;
    logic [31:0] Read_data;
    logic        uart_rxd = 1'b1;
    logic        uart_txd;
    logic        irq;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [7:0] exp_txd = '0;
    logic [7:0] exp_rxd = '0;
    logic       exp_tx_done = 1'b0;
    logic       exp_rx_ready = 1'b0;
    logic       exp_ovr = 1'b0;
    logic [1:0] exp_ien = '0;

    uart_mmio #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Address    (Address),
        .Write_data (Write_data),
        .Read_data  (Read_data),
        .uart_rxd   (uart_rxd),
        .uart_txd   (uart_txd),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_con();
        return {23'd0, 3'd0, exp_ovr, 1'b0, exp_rx_ready, exp_tx_done, exp_ien};
    endfunction

    function automatic logic exp_irq();
        return (exp_ien[0] & exp_tx_done) | (exp_ien[1] & exp_rx_ready);
    endfunction

    function automatic void model_rx(input logic [7:0] b);
`ifdef UART_RX_OVERRUN_EN
        if (exp_rx_ready) exp_ovr = 1'b1;
`endif
        exp_rxd = b;
        exp_rx_ready = 1'b1;
    endfunction

    // Side-effect-free look at a register: strobe dropped before the next rising edge.
    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        Address = a;
        MemRead = 1'b1;
        #1;
        d = Read_data;
        MemRead = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        Address = a;
        Write_data = d;
        MemWrite = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        Address = a;
        MemRead = 1'b1;
        #1;
        d = Read_data;
        @(negedge clk);
        MemRead = 1'b0;
    endtask

    // Called at the negedge right after the accepting TXD write; inj = cycle of a rogue TXD write.
    task automatic tx_frame(input logic [7:0] b, input int inj);
        logic [9:0]  frame;
        logic [31:0] d;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10 * CPB; i++) begin
            chk("tx_bit", uart_txd, frame[i / CPB]);
            if (i == inj) begin
                Address = UART_TXD_ADDR;
                Write_data = {24'd0, ~b};
                MemWrite = 1'b1;
            end else begin
                peek(UART_CON_ADDR, d);
                chk("tx_busy_high", d[CON_TX_BUSY], 1);
            end
            @(negedge clk);
            MemWrite = 1'b0;
        end
        exp_tx_done = 1'b1;
        chk("tx_idle_line", uart_txd, 1);
        peek(UART_CON_ADDR, d);
        chk("tx_end_con", d, exp_con());
        chk("tx_end_irq", irq, exp_irq());
    endtask

    // The stop bit is held at its level for the first half bit, then the line idles high.
    task automatic rx_send(input logic [7:0] b, input logic stopbit);
        logic [8:0] f;
        f = {b, 1'b0};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            uart_rxd = f[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        uart_rxd = stopbit;
        repeat (CPB / 2) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (CPB - CPB / 2) @(negedge clk);
    endtask

    task automatic wait_ready();
        logic [31:0] d;
        logic        seen;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            peek(UART_CON_ADDR, d);
            if (d[CON_RX_READY]) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rx_ready_timeout", seen, 1);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  b;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_txd", uart_txd, 1);
        chk("rst_irq", irq, 0);
        peek(UART_CON_ADDR, d); chk("rst_con", d, 0);
        peek(UART_TXD_ADDR, d); chk("rst_txd_reg", d, 0);
        peek(UART_RXD_ADDR, d); chk("rst_rxd_reg", d, 0);
        reset = 1'b1;
        @(negedge clk);
        Address = UART_TXD_ADDR;
        #1 chk("no_read_zero", Read_data, 0);
        @(negedge clk);
        peek(32'h4000_0024, d); chk("out_of_window_hi", d, 0);
        peek(32'h4000_0014, d); chk("out_of_window_lo", d, 0);

        // TX 0xA5
        wr(UART_TXD_ADDR, 32'hA5);
        exp_txd = 8'hA5;
        tx_frame(8'hA5, -1);
        rd(UART_CON_ADDR, d); chk("con_tx_done", d, 32'h004);
        exp_tx_done = 1'b0;
        rd(UART_CON_ADDR, d); chk("con_cleared", d, 32'h000);
        rd(UART_TXD_ADDR, d); chk("txd_readback", d, 32'hA5);

        // RX 0x3C with rx interrupt
        wr(UART_CON_ADDR, 32'hFFFF_FFFE);
        exp_ien = 2'b10;
        rx_send(8'h3C, 1'b1);
        model_rx(8'h3C);
        wait_ready();
        chk("rx_irq_set", irq, 1);
        rd(UART_RXD_ADDR, d); chk("rxd_3c", d, 32'h3C);
        exp_rx_ready = 1'b0;
        peek(UART_CON_ADDR, d); chk("rx_ready_clr", d, exp_con());
        chk("rx_irq_clr", irq, 0);

        // Write during busy is ignored
        wr(UART_TXD_ADDR, 32'h11);
        exp_txd = 8'h11;
        tx_frame(8'h11, 12);
        rd(UART_TXD_ADDR, d); chk("txd_ignore_mid", d, 32'h11);

        // Write on the cycle the frame ends is ignored too
        b = 8'($urandom);
        wr(UART_TXD_ADDR, {24'd0, b});
        exp_txd = b;
        tx_frame(b, 10 * CPB - 1);
        rd(UART_TXD_ADDR, d); chk("txd_ignore_end", d, {24'd0, b});
        rd(UART_CON_ADDR, d); chk("con_after_end", d, exp_con());
        exp_tx_done = 1'b0;

        // Random TX bytes with random interrupt enables
        for (int n = 0; n < 3; n++) begin
            b = 8'($urandom);
            exp_ien = 2'($urandom_range(0, 3));
            wr(UART_CON_ADDR, {30'($urandom), exp_ien});
            wr(UART_TXD_ADDR, {24'($urandom), b});
            exp_txd = b;
            tx_frame(b, -1);
            rd(UART_CON_ADDR, d); chk("rand_tx_con", d, exp_con());
            exp_tx_done = 1'b0;
            chk("rand_tx_irq_clr", irq, exp_irq());
            rd(UART_TXD_ADDR, d); chk("rand_txd_readback", d, {24'd0, b});
        end

        // Random RX bytes
        for (int n = 0; n < 3; n++) begin
            b = 8'($urandom);
            rx_send(b, 1'b1);
            model_rx(b);
            wait_ready();
            chk("rand_rx_irq", irq, exp_irq());
            rd(UART_RXD_ADDR, d); chk("rand_rxd", d, {24'd0, b});
            exp_rx_ready = 1'b0;
        end

        // Overrun: two bytes without reading RXD
        rx_send(8'h55, 1'b1);
        model_rx(8'h55);
        wait_ready();
        rx_send(8'h66, 1'b1);
        model_rx(8'h66);
        repeat (4) @(negedge clk);
        peek(UART_RXD_ADDR, d); chk("overwrite_rxd", d, 32'h66);
        rd(UART_CON_ADDR, d); chk("overrun_con", d, exp_con());
        exp_ovr = 1'b0;
        peek(UART_CON_ADDR, d); chk("overrun_clr", d, exp_con());
        rd(UART_RXD_ADDR, d); chk("rxd_66", d, 32'h66);
        exp_rx_ready = 1'b0;

        // One-cycle glitch
        @(negedge clk);
        uart_rxd = 1'b0;
        @(negedge clk);
        uart_rxd = 1'b1;
        repeat (15 * CPB) @(negedge clk);
        peek(UART_CON_ADDR, d); chk("glitch_no_ready", d, exp_con());

        // Framing error
        b = 8'($urandom);
        rx_send(b, 1'b0);
        repeat (3 * CPB) @(negedge clk);
        peek(UART_CON_ADDR, d); chk("frame_err_con", d, exp_con());
        peek(UART_RXD_ADDR, d); chk("frame_err_rxd", d, {24'd0, exp_rxd});

        // Reset in the middle of a TX frame, with irq asserted beforehand
        b = 8'($urandom);
        wr(UART_TXD_ADDR, {24'd0, b});
        exp_txd = b;
        tx_frame(b, -1);
        wr(UART_CON_ADDR, 32'h1);
        exp_ien = 2'b01;
        chk("pre_reset_irq", irq, 1);
        wr(UART_TXD_ADDR, 32'h00);
        repeat (5 * CPB + 1) @(negedge clk);
        reset = 1'b0;
        #1;
        exp_txd = '0; exp_rxd = '0; exp_tx_done = 1'b0; exp_rx_ready = 1'b0;
        exp_ovr = 1'b0; exp_ien = '0;
        chk("mid_reset_txd", uart_txd, 1);
        chk("mid_reset_irq", irq, 0);
        peek(UART_CON_ADDR, d); chk("mid_reset_con", d, 0);
        peek(UART_TXD_ADDR, d); chk("mid_reset_txd_reg", d, 0);
        peek(UART_RXD_ADDR, d); chk("mid_reset_rxd_reg", d, 0);
        @(negedge clk);
        reset = 1'b1;
        b = 8'($urandom);
        wr(UART_TXD_ADDR, {24'd0, b});
        exp_txd = b;
        tx_frame(b, -1);
        rd(UART_TXD_ADDR, d); chk("post_reset_txd", d, {24'd0, b});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_mmio.md
# uart_mmio

Memory-mapped UART peripheral occupying the 0x4000_0018–0x4000_0020 window of the CPU data bus, alongside the data memory and tube display registers. It is the bus responder for the CPU and the serial endpoint of the UART link. It serialises bytes the CPU writes, deserialises bytes arriving on the RX line, and reports status and interrupt through a control register.

## Interface
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); minimum 4
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- MemRead  in  1  bus read strobe
- MemWrite  in  1  bus write strobe
- Address  in  32  byte address
- Write_data  in  32  bus write data
- Read_data  out  32  combinational read data; 0 when MemRead=0 or address not in window
- uart_rxd  in  1  serial input, asynchronous, idle high
- uart_txd  out  1  serial output, idle high
- irq  out  1  level interrupt

## Operation
- Register map:
  - 0x4000_0018 TXD: write[7:0] starts a transmit; reads return the last written byte.
  - 0x4000_001C RXD: read[7:0] returns the last received byte.
  - 0x4000_0020 CON: 9 bits, zero-extended on read.
- CON bits:
  - [0] tx_irq_en, R/W
  - [1] rx_irq_en, R/W
  - [2] tx_done, RO; set at end of stop bit; cleared by a CON read
  - [3] rx_ready, RO; set on a valid byte; cleared by an RXD read
  - [4] tx_busy, RO
  - [5] rx_overrun (see Configuration)
  - [8:6] read 0
- CON writes affect only [1:0].
- Read side effects are registered on the rising edge while MemRead=1 and Address matches.
- irq = (tx_irq_en & tx_done) | (rx_irq_en & rx_ready).
- TX FSM, states IDLE→START→DATA→STOP→IDLE:
  - Frame is 8N1, LSB first.
  - A TXD write in IDLE latches the byte and enters START.
  - A TXD write while tx_busy is ignored, and TXD readback is unchanged.
- RX FSM, states IDLE→START→DATA→STOP→IDLE:
  - uart_rxd passes through a 2-flop synchroniser.
  - A synchronised low in IDLE enters START.
  - At CLKS_PER_BIT/2 the line is re-checked; if it is high (glitch), return to IDLE.
  - Each data bit and the stop bit are sampled every CLKS_PER_BIT cycles from that mid-point.
  - Stop bit = 1: store the byte and set rx_ready. Stop bit = 0: framing error; discard the byte, leave flags unchanged, return to IDLE.
  - A new valid byte while rx_ready=1 overwrites RXD.
- Simultaneous events:
  - Flag set and flag clear in the same cycle: set wins, for both tx_done and rx_ready.
  - A TXD write in the same cycle the TX FSM returns to IDLE is ignored.
- Reset, including mid-frame: both FSMs go to IDLE, uart_txd=1, all CON bits 0, TXD/RXD=0, irq=0. A partially received frame is dropped.

## Timing
- TXD write at edge N: tx_busy=1 and uart_txd=0 after edge N.
- Each bit lasts exactly CLKS_PER_BIT cycles; a full frame is 10×CLKS_PER_BIT cycles.
- tx_done=1 and tx_busy=0 at the edge ending the stop bit.
- RX: rx_ready rises 2 cycles (synchroniser) plus 9.5×CLKS_PER_BIT cycles after the line's falling edge, ±1 cycle.
- Read_data has zero latency and depends only on current register state.
- No back-to-back TX pipelining; the next write is accepted from the first IDLE cycle.

## Configuration
- UART_RX_OVERRUN_EN defined:
  - CON[5] rx_overrun is set when a valid byte completes while rx_ready=1.
  - Cleared by a CON read; set wins against a same-cycle clear.
  - It is not included in the irq equation.
- Undefined: CON[5] reads 0 and no overrun storage is built.

## Structure
- Package uart_mmio_pkg holds:
  - Address constants UART_TXD_ADDR, UART_RXD_ADDR, UART_CON_ADDR
  - CON bit index constants
  - Shared 2-bit state encoding uart_state_t (IDLE, START, DATA, STOP)
- One sub-module, uart_rx_core, contains the synchroniser, RX FSM and bit/sample counters. It outputs byte[7:0] plus a one-cycle byte_valid pulse.
- The TX FSM, registers and bus decode stay in uart_mmio.

## Test plan
- CLKS_PER_BIT=4, write 0xA5 to TXD → uart_txd sequence 0,1,0,1,0,0,1,0,1,1, 4 cycles each; tx_busy high for 40 cycles; tx_done=1; CON read returns 0x004 and then 0x000.
- Drive serial 0x3C on uart_rxd with rx_irq_en=1 → rx_ready=1, irq=1; RXD read returns 0x3C; next cycle rx_ready=0, irq=0.
- Write 0x11 to TXD, then write 0x22 mid-frame → only 0x11 is serialised; TXD reads 0x11.
- Send 0x55 then 0x66 without reading RXD → RXD=0x66; CON[5]=1 with UART_RX_OVERRUN_EN, 0 without.
- 1-cycle low glitch on uart_rxd → no rx_ready. Frame with stop bit 0 → byte discarded, rx_ready stays 0.
- Assert reset mid-TX frame → uart_txd=1, CON=0, irq=0 immediately; after release, a new TXD write transmits normally.
